// File: rtl/pll_hop_sequencer_pkg.sv
// ============================================================================
// Module  : pll_hop_sequencer_pkg
// Brief   : Shared widths, handshake timeouts and state encoding for the
//           PLL frequency-hop sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_hop_sequencer_pkg;

  localparam int INT_W        = 12;
  localparam int FRAC_W       = 25;
  localparam int WORD_W       = INT_W + FRAC_W;
  localparam int ACK_TIMEOUT  = 255;
  localparam int WAIT_TIMEOUT = 65535;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PRE_REQ  = 4'd1,
    S_PRE_ACK  = 4'd2,
    S_PRE_WAIT = 4'd3,
    S_DWELL    = 4'd4,
    S_LD_REQ   = 4'd5,
    S_LD_ACK   = 4'd6,
    S_LD_WAIT  = 4'd7,
    S_DONE     = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pll_hop_sequencer_accum.sv
// ============================================================================
// Module  : pll_word_accum
// Brief   : 37-bit {INT,FRAC} add/subtract; FRAC carry/borrow ripples into
//           INT naturally because the word is treated as one integer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_word_accum
  import pll_hop_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] acc,
  input  logic [WORD_W-1:0] step,
  input  logic              dn,
  output logic [WORD_W-1:0] nxt
);

  // Next hop word, wrapping modulo 2^37 in either direction.
  always_comb begin
    nxt = dn ? (acc - step) : (acc + step);
  end

endmodule

`default_nettype wire

// File: rtl/pll_hop_sequencer.sv
// ============================================================================
// Module  : pll_hop_sequencer
// Brief   : Sweeps a synthesizer through a list of {INT,FRAC} words. Each
//           word is pre-loaded during the previous hop's dwell and committed
//           with a load request once both the pre-load and dwell are done.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_hop_sequencer
  import pll_hop_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [INT_W-1:0]  start_int,
  input  logic [FRAC_W-1:0] start_frac,
  input  logic [INT_W-1:0]  step_int,
  input  logic [FRAC_W-1:0] step_frac,
  input  logic              step_dn,
  input  logic [9:0]        num_hops,
  input  logic [15:0]       dwell,
  output logic [INT_W-1:0]  ints,
  output logic [FRAC_W-1:0] fracs,
  output logic              pre_load,
  output logic              load,
  input  logic              pll_busy,
  output logic              seq_busy,
  output logic [9:0]        hop_index,
  output logic              hop_strobe,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] step;
  logic [WORD_W-1:0] acc_next;
  logic              dn;
  logic [9:0]        last_hop;
  logic [9:0]        hop;
  logic [15:0]       dwell_cfg;
  logic [15:0]       dwell_cnt;
  logic [15:0]       tmo;
  logic              abort_pend;
  logic              last_done;
  logic              abort_seen;

  // An abort seen this cycle or remembered from an earlier one.
  assign abort_seen = abort | abort_pend;

  pll_word_accum u_accum (
    .acc  (acc),
    .step (step),
    .dn   (dn),
    .nxt  (acc_next)
  );

  // Sequencer state machine with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      step       <= '0;
      dn         <= 1'b0;
      last_hop   <= '0;
      hop        <= '0;
      dwell_cfg  <= '0;
      dwell_cnt  <= '0;
      tmo        <= '0;
      abort_pend <= 1'b0;
      last_done  <= 1'b0;
      ints       <= '0;
      fracs      <= '0;
      pre_load   <= 1'b0;
      load       <= 1'b0;
      seq_busy   <= 1'b0;
      hop_index  <= '0;
      hop_strobe <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      pre_load   <= 1'b0;
      load       <= 1'b0;
      hop_strobe <= 1'b0;
      done       <= 1'b0;
      // Dwell keeps running through the next word's pre-load handshake.
      if (dwell_cnt != 16'd0) dwell_cnt <= dwell_cnt - 16'd1;
      if (abort && (state != S_IDLE)) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start && !abort) begin
            acc       <= {start_int, start_frac};
            step      <= {step_int, step_frac};
            dn        <= step_dn;
            last_hop  <= (num_hops == 10'd0) ? 10'd0 : (num_hops - 10'd1);
            dwell_cfg <= (dwell == 16'd0) ? 16'd1 : dwell;
            hop       <= '0;
            dwell_cnt <= '0;
            last_done <= 1'b0;
            err       <= 1'b0;
            seq_busy  <= 1'b1;
            state     <= S_PRE_REQ;
          end
        end

        S_PRE_REQ: begin
          if (!pll_busy) begin
            ints     <= acc[WORD_W-1:FRAC_W];
            fracs    <= acc[FRAC_W-1:0];
            pre_load <= 1'b1;
            tmo      <= '0;
            state    <= S_PRE_ACK;
          end
        end

        S_PRE_ACK, S_LD_ACK: begin
          if (pll_busy) begin
            tmo   <= '0;
            state <= (state == S_PRE_ACK) ? S_PRE_WAIT : S_LD_WAIT;
          end else if (tmo >= 16'(ACK_TIMEOUT)) begin
            err      <= 1'b1;
            seq_busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        S_PRE_WAIT: begin
          if (!pll_busy) begin
            if (abort_seen) begin
              seq_busy <= 1'b0;
              state    <= S_IDLE;
            end else if (hop == 10'd0) begin
              state <= S_LD_REQ;
            end else begin
              state <= S_DWELL;
            end
          end else if (tmo >= 16'(WAIT_TIMEOUT)) begin
            err      <= 1'b1;
            seq_busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        S_DWELL: begin
          if (abort_seen) begin
            seq_busy <= 1'b0;
            state    <= S_IDLE;
          end else if (dwell_cnt == 16'd0) begin
            if (last_done) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_LD_REQ;
            end
          end
        end

        S_LD_REQ: begin
          if (!pll_busy && (dwell_cnt == 16'd0)) begin
            load  <= 1'b1;
            tmo   <= '0;
            state <= S_LD_ACK;
          end
        end

        S_LD_WAIT: begin
          if (!pll_busy) begin
            hop_strobe <= 1'b1;
            hop_index  <= hop;
            dwell_cnt  <= dwell_cfg;
            if (abort_seen) begin
              seq_busy <= 1'b0;
              state    <= S_IDLE;
            end else if (hop == last_hop) begin
              last_done <= 1'b1;
              state     <= S_DWELL;
            end else begin
              acc   <= acc_next;
              hop   <= hop + 10'd1;
              state <= S_PRE_REQ;
            end
          end else if (tmo >= 16'(WAIT_TIMEOUT)) begin
            err      <= 1'b1;
            seq_busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        S_DONE: begin
          seq_busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          seq_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pll_hop_sequencer.md
PLL_HOP_SEQUENCER -- requirements
Module: pll_hop_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-002 SHALL have: start  in  1  begin sweep (single-cycle pulse); abort  in  1  stop sweep (pulse).
REQ-003 SHALL have: start_int  in  12  INT of hop 0; start_frac  in  25  FRAC of hop 0.
REQ-004 SHALL have: step_int  in  12; step_frac  in  25  per-hop increment; step_dn  in  1  1 = subtract step.
REQ-005 SHALL have: num_hops  in  10  hop count (0 treated as 1); dwell  in  16  cycles per hop after load completes.
REQ-006 SHALL have: ints  out  12; fracs  out  25  word presented to the synthesizer controller.
REQ-007 SHALL have: pre_load  out  1; load  out  1  requests to the synthesizer controller; pll_busy  in  1  controller busy.
REQ-008 SHALL have: seq_busy  out  1; hop_index  out  10; hop_strobe  out  1  one-cycle pulse per completed load; done  out  1  one-cycle pulse; err  out  1  sticky handshake timeout.

Function
REQ-009 SHALL capture all config inputs on an accepted start; later config changes SHALL NOT affect the running sweep.
REQ-010 SHALL accept start only in IDLE; start outside IDLE SHALL be ignored.
REQ-011 SHALL hold a 37-bit accumulator {INT,FRAC}; next = acc +/- {step_int,step_frac} modulo 2^37; FRAC carry/borrow SHALL propagate into INT.
REQ-012 States: IDLE, PRE_REQ, PRE_ACK, PRE_WAIT, DWELL, LD_REQ, LD_ACK, LD_WAIT, DONE.
REQ-013 PRE_REQ: when pll_busy=0, drive ints/fracs=acc and pre_load=1 for exactly one cycle -> PRE_ACK.
REQ-014 PRE_ACK: wait pll_busy=1 -> PRE_WAIT; PRE_WAIT: wait pll_busy=0 -> LD_REQ for hop 0, else DWELL.
REQ-015 LD_REQ: when pll_busy=0 and dwell expired (hop 0: immediately), load=1 one cycle -> LD_ACK -> LD_WAIT (same ack rules).
REQ-016 On pll_busy falling in LD_WAIT: hop_strobe=1 one cycle, dwell counter loads dwell, hop_index = current hop.
REQ-017 After a non-final load, SHALL step accumulator and pre-load the next word during the dwell (double-buffer); load SHALL wait for both pre-load completion and dwell expiry.
REQ-018 dwell=0 SHALL behave as dwell=1.
REQ-019 After final hop's dwell expires -> DONE: done=1 one cycle -> IDLE; ints/fracs SHALL hold the last word.
REQ-020 ints/fracs SHALL be stable from request cycle until the matching busy falling edge.
REQ-021 Any ACK state waiting >255 cycles for pll_busy=1, or any WAIT state >65535 cycles for pll_busy=0, SHALL set err and go to IDLE without done.
REQ-022 abort in IDLE/DWELL/DONE SHALL go to IDLE next cycle; in REQ/ACK/WAIT states the abort SHALL be remembered, the current transaction completed, then IDLE; no done on abort.
REQ-023 start and abort in the same IDLE cycle: abort wins.
REQ-024 seq_busy SHALL be 1 in every state except IDLE.
REQ-025 pre_load and load SHALL never be 1 in the same cycle.

Reset
REQ-026 On rst=0: state IDLE; ints, fracs, hop_index, counters 0; pre_load, load, hop_strobe, done, seq_busy, err 0.
REQ-027 Reset mid-handshake SHALL drop requests immediately; err cleared only by reset or accepted start.

Structure
REQ-028 Shared package SHALL hold state encoding, INT_W=12, FRAC_W=25, ACK_TIMEOUT=255, WAIT_TIMEOUT=65535.
REQ-029 Single module; optional sub-module pll_word_accum for the 37-bit add/subtract.

Verification
REQ-030 start_int=100, frac=0, step_frac=2^24, num_hops=3, dwell=10, controller model -> words (100,0),(100,2^24),(101,0); 3 hop_strobes; done once.
REQ-031 step_dn=1 from (100,0) by frac 1 -> second word (99,2^25-1).
REQ-032 Model holds pll_busy low after pre_load for 300 cycles -> err=1, IDLE, no done.
REQ-033 abort during PRE_WAIT -> transaction finishes, IDLE, no further load, no done.
REQ-034 dwell=2 with controller busy 40 cycles per write -> load issued only after pre-load done; hop spacing set by controller, not dwell.
REQ-035 rst=0 mid-LD_ACK -> all outputs zero next cycle; new start runs normally.
